// File: rtl/pc_fetch_ctrl.sv
// Fetch sequencer: owns the PC, issues req/ack instruction fetches into a
// one-entry output buffer, applies redirects and flags a hung memory.
module pc_fetch_ctrl #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned TIMEOUT  = 16,
  parameter int unsigned CNT_W    = 5
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst,
  output logic [31:0] inst_pc,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        fetch_err,
  output logic [31:0] pc
);

  localparam int unsigned XLEN = 32;
  // Word-aligned reset PC; low bits are dropped even if mis-set.
  localparam logic [XLEN-1:0] RST_PC = {RESET_PC[XLEN-1:2], 2'b00};
  // Counter value in the last cycle a request may wait before timing out.
  localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_HOLD  = 2'd2,
    S_ERR   = 2'd3
  } state_t;

  state_t            state_q;
  logic [XLEN-1:0]   pc_q;
  logic [XLEN-1:0]   addr_q;
  logic              kill_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [XLEN-1:0]   redir_pc;
  logic [XLEN-1:0]   addr_inc;

  // Redirect target forced word-aligned; sequential next address wraps mod 2^32.
  assign redir_pc  = {redirect_pc[XLEN-1:2], 2'b00};
  assign addr_inc  = addr_q + XLEN'(4);

  // Address register drives the bus directly; it only changes between requests.
  assign imem_addr = addr_q;
  assign pc        = pc_q;

  // Fetch FSM with all outputs registered.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      pc_q       <= RST_PC;
      addr_q     <= RST_PC;
      kill_q     <= 1'b0;
      cnt_q      <= '0;
      imem_req   <= 1'b0;
      inst_valid <= 1'b0;
      inst       <= '0;
      inst_pc    <= '0;
      fetch_err  <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          state_q  <= S_FETCH;
          imem_req <= 1'b1;
          cnt_q    <= '0;
          if (redirect_valid) begin
            pc_q   <= redir_pc;
            addr_q <= redir_pc;
          end else begin
            addr_q <= pc_q;
          end
        end

        S_FETCH: begin
          if (imem_ack) begin
            cnt_q <= '0;
            if (redirect_valid) begin
              // Returned word belongs to the old path; refetch at the target.
              pc_q   <= redir_pc;
              addr_q <= redir_pc;
              kill_q <= 1'b0;
            end else if (kill_q) begin
              // Stale response of a redirected request; restart at newest PC.
              addr_q <= pc_q;
              kill_q <= 1'b0;
            end else begin
              inst       <= imem_rdata;
              inst_pc    <= addr_q;
              inst_valid <= 1'b1;
              pc_q       <= addr_inc;
              imem_req   <= 1'b0;
              state_q    <= S_HOLD;
            end
          end else begin
            // Outstanding request is kept alive; its data will be dropped.
            if (redirect_valid) begin
              pc_q   <= redir_pc;
              kill_q <= 1'b1;
            end
            if (cnt_q == TMO_LAST) begin
              fetch_err  <= 1'b1;
              imem_req   <= 1'b0;
              inst_valid <= 1'b0;
              state_q    <= S_ERR;
            end else begin
              cnt_q <= cnt_q + CNT_W'(1);
            end
          end
        end

        S_HOLD: begin
          if (redirect_valid) begin
            // Flush the buffer even if decode is taking it this cycle.
            pc_q       <= redir_pc;
            addr_q     <= redir_pc;
            inst_valid <= 1'b0;
            imem_req   <= 1'b1;
            cnt_q      <= '0;
            state_q    <= S_FETCH;
          end else if (inst_ready) begin
            inst_valid <= 1'b0;
            addr_q     <= pc_q;
            imem_req   <= 1'b1;
            cnt_q      <= '0;
            state_q    <= S_FETCH;
          end
        end

        S_ERR: begin
          state_q <= S_ERR;
        end

        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// Self-checking bench for pc_fetch_ctrl with a latency-programmable memory
// model and an instruction scoreboard.
module tb_pc_fetch_ctrl;

  logic        clk;
  logic        rst;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        fetch_err;
  logic [31:0] pc;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] word;
  } exp_t;

  exp_t        sb[$];
  exp_t        e;
  logic [31:0] req_log[$];
  int          checks;
  int          errors;
  int          extra;
  int          mem_lat;
  logic        mem_en;
  int          wait_cnt;

  pc_fetch_ctrl #(
    .RESET_PC (32'h0000_0000),
    .TIMEOUT  (16),
    .CNT_W    (5)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_ack       (imem_ack),
    .imem_rdata     (imem_rdata),
    .inst_valid     (inst_valid),
    .inst_ready     (inst_ready),
    .inst           (inst),
    .inst_pc        (inst_pc),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .fetch_err      (fetch_err),
    .pc             (pc)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a ^ 32'hDEAD_BEEF) + 32'h0001_0001;
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Memory: acks combinationally once a request has waited mem_lat cycles.
  always_comb begin
    imem_ack   = mem_en && imem_req && (wait_cnt >= mem_lat);
    imem_rdata = mem_word(imem_addr);
  end

  always @(posedge clk or posedge rst) begin
    if (rst)                         wait_cnt <= 0;
    else if (imem_req && imem_ack)   wait_cnt <= 0;
    else if (imem_req)               wait_cnt <= wait_cnt + 1;
    else                             wait_cnt <= 0;
  end

  // Monitor: log accepted requests and score consumed instructions.
  always @(negedge clk) begin
    if (!rst) begin
      if (imem_req && imem_ack) req_log.push_back(imem_addr);
      if (inst_valid && inst_ready && !redirect_valid) begin
        if (sb.size() == 0) extra++;
        else begin
          e = sb.pop_front();
          chk("sb_pc", inst_pc, e.pc);
          chk("sb_inst", inst, e.word);
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic push_exp(input logic [31:0] a);
    exp_t x;
    x.pc   = a;
    x.word = mem_word(a);
    sb.push_back(x);
  endtask

  task automatic end_test(input string tag);
    chk({tag, "_sb_left"}, sb.size(), 0);
    chk({tag, "_sb_extra"}, extra, 0);
  endtask

  // Asserts reset mid-cycle, checks immediate reset values, then releases.
  task automatic do_reset();
    rst = 1'b1;
    #1;
    chk("rst_req", imem_req, 0);
    chk("rst_addr", imem_addr, 32'h0);
    chk("rst_valid", inst_valid, 0);
    chk("rst_inst", inst, 32'h0);
    chk("rst_inst_pc", inst_pc, 32'h0);
    chk("rst_err", fetch_err, 0);
    chk("rst_pc", pc, 32'h0);
    sb.delete();
    req_log.delete();
    extra          = 0;
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0;
    inst_ready     = 1'b0;
    mem_lat        = 0;
    mem_en         = 1'b1;
    step();
    step();
    rst = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    checks = 0; errors = 0; extra = 0;
    rst = 1'b1; mem_lat = 0; mem_en = 1'b1;
    inst_ready = 1'b0; redirect_valid = 1'b0; redirect_pc = 32'h0;
    #12;

    // T1: zero-wait memory, decode always ready.
    do_reset();
    inst_ready = 1'b1;
    push_exp(32'h0); push_exp(32'h4); push_exp(32'h8);
    chk("t1_idle_req", imem_req, 0);
    for (int i = 0; i < 6; i++) begin
      step();
      if (i % 2 == 0) begin
        chk("t1_req", imem_req, 1);
        chk("t1_addr", imem_addr, 32'(4 * (i / 2)));
        chk("t1_novalid", inst_valid, 0);
      end else begin
        chk("t1_valid", inst_valid, 1);
        chk("t1_inst_pc", inst_pc, 32'(4 * (i / 2)));
        chk("t1_noreq", imem_req, 0);
      end
    end
    step();
    inst_ready = 1'b0;
    chk("t1_logn", req_log.size() >= 3, 1);
    if (req_log.size() >= 3) begin
      chk("t1_log0", req_log[0], 32'h0);
      chk("t1_log1", req_log[1], 32'h4);
      chk("t1_log2", req_log[2], 32'h8);
    end
    end_test("t1");

    // T2: decode stalls for 5 cycles after the first fetch.
    do_reset();
    push_exp(32'h0); push_exp(32'h4);
    step();
    step();
    for (int i = 0; i < 5; i++) begin
      chk("t2_hold_valid", inst_valid, 1);
      chk("t2_hold_inst", inst, mem_word(32'h0));
      chk("t2_hold_pc", inst_pc, 32'h0);
      chk("t2_hold_noreq", imem_req, 0);
      step();
    end
    inst_ready = 1'b1;
    step();
    chk("t2_next_req", imem_req, 1);
    chk("t2_next_addr", imem_addr, 32'h4);
    step();
    step();
    inst_ready = 1'b0;
    end_test("t2");

    // T3: redirect while a 3-cycle-delayed request is outstanding.
    do_reset();
    mem_lat    = 3;
    inst_ready = 1'b1;
    push_exp(32'h100);
    step();
    step();
    redirect_valid = 1'b1;
    redirect_pc    = 32'h100;
    chk("t3_w1_addr", imem_addr, 32'h0);
    step();
    redirect_valid = 1'b0;
    chk("t3_w2_addr", imem_addr, 32'h0);
    chk("t3_w2_req", imem_req, 1);
    chk("t3_w2_pc", pc, 32'h100);
    step();
    chk("t3_w3_addr", imem_addr, 32'h0);
    chk("t3_w3_ack", imem_ack, 1);
    step();
    chk("t3_kill_novalid", inst_valid, 0);
    chk("t3_new_req", imem_req, 1);
    chk("t3_new_addr", imem_addr, 32'h100);
    for (int k = 0; k < 20 && !inst_valid; k++) step();
    chk("t3_valid", inst_valid, 1);
    chk("t3_inst_pc", inst_pc, 32'h100);
    step();
    inst_ready = 1'b0;
    chk("t3_logn", req_log.size() >= 2, 1);
    if (req_log.size() >= 2) begin
      chk("t3_log0", req_log[0], 32'h0);
      chk("t3_log1", req_log[1], 32'h100);
    end
    end_test("t3");

    // T4: redirect to an unaligned target in HOLD with ready asserted.
    do_reset();
    inst_ready = 1'b1;
    push_exp(32'h200);
    step();
    step();
    chk("t4_hold_valid", inst_valid, 1);
    redirect_valid = 1'b1;
    redirect_pc    = 32'h203;
    step();
    redirect_valid = 1'b0;
    chk("t4_flush", inst_valid, 0);
    chk("t4_req", imem_req, 1);
    chk("t4_addr", imem_addr, 32'h200);
    chk("t4_pc", pc, 32'h200);
    step();
    chk("t4_valid", inst_valid, 1);
    chk("t4_inst", inst, mem_word(32'h200));
    step();
    inst_ready = 1'b0;
    end_test("t4");

    // T5: memory never acks; timeout must latch the error state.
    do_reset();
    mem_en         = 1'b0;
    redirect_valid = 1'b1;
    redirect_pc    = 32'h80;
    step();
    redirect_valid = 1'b0;
    for (int k = 1; k <= 16; k++) begin
      chk("t5_wait_err", fetch_err, 0);
      chk("t5_wait_req", imem_req, 1);
      step();
    end
    chk("t5_err", fetch_err, 1);
    chk("t5_err_req", imem_req, 0);
    chk("t5_err_valid", inst_valid, 0);
    mem_en         = 1'b1;
    inst_ready     = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc    = 32'h40;
    for (int k = 0; k < 4; k++) begin
      step();
      chk("t5_stuck_err", fetch_err, 1);
      chk("t5_stuck_req", imem_req, 0);
      chk("t5_stuck_pc", pc, 32'h80);
    end
    redirect_valid = 1'b0;
    inst_ready     = 1'b0;
    end_test("t5");

    // T6: fetch at the top of the address space wraps pc to zero.
    do_reset();
    inst_ready     = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc    = 32'hFFFF_FFFC;
    push_exp(32'hFFFF_FFFC);
    step();
    redirect_valid = 1'b0;
    chk("t6_addr", imem_addr, 32'hFFFF_FFFC);
    step();
    chk("t6_wrap_pc", pc, 32'h0);
    chk("t6_inst_pc", inst_pc, 32'hFFFF_FFFC);
    mem_lat = 5;
    step();
    chk("t6_mid_req", imem_req, 1);
    chk("t6_mid_addr", imem_addr, 32'h0);
    end_test("t6");

    // Reset asserted mid-FETCH; do_reset checks values immediately.
    do_reset();
    step();
    chk("t6_after_req", imem_req, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pc_fetch_ctrl.md
Name: pc_fetch_ctrl

Overview:
- Fetch sequencer that owns the program counter for the datapath.
- Issues instruction-memory requests using a req/ack handshake and holds the fetched word in a one-entry output buffer until the decode stage takes it.
- Applies branch/jump redirects and advances PC by 4 per completed fetch.
- Detects a hung memory through an ack timeout.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset; bits [1:0] must be 0.
- TIMEOUT, 16, max cycles imem_req may stay unacknowledged before error (min 2).
- CNT_W, 5, width of timeout counter; 2^CNT_W > TIMEOUT.

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-high reset
- imem_req  out  1  fetch request; held until imem_ack
- imem_addr  out  32  fetch address; stable while imem_req=1
- imem_ack  in  1  memory accepted request; imem_rdata valid this cycle
- imem_rdata  in  32  instruction word
- inst_valid  out  1  output buffer holds a valid instruction
- inst_ready  in  1  decode consumes buffer when inst_valid & inst_ready
- inst  out  32  buffered instruction
- inst_pc  out  32  address of buffered instruction
- redirect_valid  in  1  one-cycle branch/jump redirect
- redirect_pc  in  32  redirect target; bits [1:0] ignored (forced 0)
- fetch_err  out  1  sticky ack-timeout flag
- pc  out  32  current next-fetch PC (pc_q)

Behaviour:
- Reset (async assert, any state): state=IDLE, pc_q=RESET_PC, addr_q=RESET_PC, imem_req=0, imem_addr=RESET_PC, inst_valid=0, inst=0, inst_pc=0, fetch_err=0, kill=0, counter=0.
- States: IDLE, FETCH, HOLD, ERR.
- IDLE: imem_req=0. Next cycle goes to FETCH with addr_q<=pc_q. There is exactly 1 idle cycle after reset release.
- FETCH: imem_req=1, imem_addr=addr_q. Counter increments each cycle without ack.
  - On imem_ack with kill=0: inst<=imem_rdata, inst_pc<=addr_q, inst_valid<=1, pc_q<=addr_q+4 (wraps mod 2^32), counter<=0, go to HOLD.
  - On imem_ack with kill=1: data is discarded, kill<=0, addr_q<=pc_q, stay in FETCH (new request next cycle).
- HOLD: imem_req=0, inst_valid=1, and inst/inst_pc stay stable. On inst_ready: inst_valid<=0, addr_q<=pc_q, go to FETCH. Throughput is 1 instruction per 2 cycles at best with a zero-wait memory.
- Ack latency: a request in cycle N acked in cycle N gives inst_valid=1 in cycle N+1.
- Redirect (highest priority, evaluated every cycle except ERR):
  - IDLE or HOLD: pc_q<=redirect_pc, addr_q<=redirect_pc, inst_valid<=0 (buffer flushed even if inst_ready=1 same cycle), go to FETCH.
  - FETCH without ack: the outstanding request must not be dropped. Set pc_q<=redirect_pc and kill<=1; imem_addr keeps the old addr_q until ack.
  - FETCH with ack same cycle: data is discarded, pc_q<=addr_q<=redirect_pc, stay in FETCH.
  - Redirect while kill=1 already: pc_q is overwritten with the newest target; kill stays 1.
- Timeout: in FETCH, when the counter reaches TIMEOUT with no ack, set fetch_err<=1, imem_req<=0, inst_valid<=0, go to ERR. ERR is terminal until rst and ignores redirect, ack and ready. An ack arriving in the same cycle the counter hits TIMEOUT wins: normal completion, no error.
- imem_ack is ignored outside FETCH.
- pc output = pc_q at all times.

Test Plan:
- Reset release, memory acks every request combinationally, inst_ready=1 -> imem_addr sequence 0x0,0x4,0x8; inst_valid pulses every 2nd cycle; inst_pc matches; first request 1 cycle after reset release.
- inst_ready=0 for 5 cycles after first fetch -> inst/inst_pc held at 0x0 data, imem_req=0 throughout; on ready the next request is at 0x4.
- Ack delayed 3 cycles, redirect_valid to 0x100 in wait cycle 1 -> imem_addr stays 0x0 until ack, returned word not presented, next request at 0x100, inst_pc=0x100.
- Redirect to 0x203 in HOLD with inst_ready=1 same cycle -> buffer flushed, next imem_addr=0x200.
- No ack with TIMEOUT=16 -> fetch_err=1 after 16 waiting cycles, imem_req=0, FSM stuck until rst, then pc=RESET_PC.
- pc_q=0xFFFF_FFFC fetch completes -> pc=0x0000_0000 (wrap); rst asserted mid-FETCH -> all outputs take reset values immediately.
